stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
Parameterised N-to-1 streaming multiplexer with a per-channel valid/ready handshake and a registered output stage.
- Selects one of N M-bit input channels, either by external select or by round-robin arbitration.
- Holds the output beat under backpressure.
- Flags out-of-range selects.
- Sits between multiple producer blocks and a single consumer, e.g. shared bus or display/UART sink.

Parameters:
N, 4, number of input channels (2..16, need not be a power of two)
M, 8, data width per channel in bits
MODE, 1, 0 = external select via sel; 1 = round-robin arbitration (sel ignored)
S, $clog2(N) (minimum 1), select/channel-index width; derived, not overridden

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
sel  input  S  channel select, used only when MODE=0
din  input  M*N  packed input data; channel i at din[M*i+M-1:M*i]
in_valid  input  N  per-channel data valid
in_ready  output  N  per-channel ready (combinational)
dout  output  M  registered output data
out_valid  output  1  registered output valid
out_ready  input  1  consumer ready
out_ch  output  S  index of the channel that supplied dout
sel_err  output  1  registered; high while sel>=N in MODE=0

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: dout=0, out_valid=0, out_ch=0, sel_err=0, rr pointer ptr=0, lock=0.
  - Reset mid-transfer discards the held beat.
  - Beats are not replayed after reset.
- Load condition: load = ~out_valid | out_ready. The output register accepts a beat only when load=1.
- Grant, MODE=0:
  - g=sel, gv = (sel<N).
  - If sel>=N: no in_ready asserted, nothing loaded, sel_err=1 on the next edge. sel_err clears the edge after sel returns in range.
- Grant, MODE=1:
  - g = first i with in_valid[i]=1, searching ptr, ptr+1, ... N-1, 0, ... ptr-1 (wrap modulo N).
  - gv = |in_valid.
- in_ready[i] = load & gv & (i==g). At most one bit is set. In MODE=0 it does not depend on in_valid.
- Transfer: occurs on channel g when in_valid[g] & in_ready[g].
  - Next edge: dout<=din slice g, out_ch<=g, out_valid<=1.
  - MODE=1: ptr <= (g==N-1) ? 0 : g+1.
- Drain: out_valid & out_ready with no new transfer gives out_valid<=0. dout and out_ch hold their last values.
- Simultaneous drain and transfer in the same cycle: the new beat replaces the old one. Throughput is 1 beat/cycle, with no bubble.
- Backpressure: while out_valid & ~out_ready, dout, out_ch and out_valid hold, and all in_ready=0.
- Latency: 1 cycle from transfer to out_valid.
- Idle: no in_valid set means no transfer, and ptr holds.
- sel_err is always 0 when MODE=1.

Optional Feature:
Macro STREAM_MUX_PKT_LOCK_EN.
- Defined:
  - Adds ports in_last (input, N) and out_last (output, registered, reset 0), which travel with the beat.
  - After a transfer with in_last[g]=0, lock<=1 and the grant is held at g, ignoring both sel and the rr search, until a transfer with in_last[g]=1; then lock<=0.
  - In MODE=1, ptr advances only on the last beat.
  - While locked, in_ready follows the held channel even if its in_valid=0, and no other channel is served.
  - sel_err is still reported while locked, but does not block the locked channel.
- Undefined: no in_last/out_last ports, and arbitration is per beat.

Test Plan:
1. MODE=1, N=4, M=8: all in_valid=1 with din={8'h44,8'h33,8'h22,8'h11} and out_ready=1 -> dout sequence 11,22,33,44,11 on consecutive cycles, out_ch 0,1,2,3,0.
2. MODE=1: only in_valid[2] and in_valid[0] set, ptr=1 -> channel 2 served first, then 0, then 2.
3. Backpressure: out_ready=0 for 3 cycles after a beat 8'hA5 is loaded -> dout=A5 and out_valid=1 held, in_ready=0; on the out_ready=1 cycle the next beat loads with no gap.
4. MODE=0, N=3: sel=2 with din slice 8'h7E -> dout=7E, out_ch=2; sel=3 -> in_ready=0, sel_err=1 next cycle, out_valid drops after drain.
5. Assert rst_n=0 asynchronously while out_valid=1 and out_ready=0 -> all outputs 0 immediately; after release, arbitration restarts at channel 0.
6. With STREAM_MUX_PKT_LOCK_EN, MODE=1: channel 1 sends a 3-beat packet (last on beat 3) while channel 2 is valid -> beats 1,1,1 then channel 2; out_last=1 only on the third beat.

Source files
------------

// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_rr
// Purpose  : N-to-1 valid/ready stream multiplexer with a registered output
//            stage. The channel is picked by an external select (MODE=0) or
//            by round-robin arbitration (MODE=1). Out-of-range selects are
//            flagged on sel_err.
// Options  : STREAM_MUX_PKT_LOCK_EN adds in_last/out_last and holds the grant
//            on one channel until the last beat of its packet is taken.
// Revision : 1.0 - initial release
// ============================================================================
module stream_mux_rr #(
  parameter int N    = 4,
  parameter int M    = 8,
  parameter int MODE = 1,
  parameter int S    = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [S-1:0]   sel,
  input  logic [M*N-1:0] din,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  output logic [M-1:0]   dout,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [S-1:0]   out_ch,
  output logic           sel_err
`ifdef STREAM_MUX_PKT_LOCK_EN
  ,
  input  logic [N-1:0]   in_last,
  output logic           out_last
`endif
);

  localparam logic [S-1:0] c_last_ch = S'(N - 1);
  localparam logic [S-1:0] c_one     = S'(1);

  logic [S-1:0] r_ptr;
  logic [S-1:0] w_base_gnt;
  logic         w_base_gv;
  logic         w_sel_bad;
  logic [S-1:0] w_gnt;
  logic         w_gv;
  logic         w_load;
  logic         w_xfer;
  logic         w_last_beat;

  // The output register may take a new beat when empty or being drained.
  assign w_load = ~out_valid | out_ready;

  generate
    if (MODE == 0) begin : g_ext_sel
      logic w_unused_ptr;
      assign w_base_gnt   = sel;
      assign w_base_gv    = (int'(sel) < N);
      assign w_sel_bad    = ~w_base_gv;
      assign w_unused_ptr = ^r_ptr;
    end else begin : g_rr
      logic w_unused_sel;
      logic w_found;
      // Rotating-priority search starting at the round-robin pointer.
      always_comb begin
        w_base_gnt = r_ptr;
        w_found    = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (!w_found && in_valid[(int'(r_ptr) + k) % N]) begin
            w_base_gnt = S'((int'(r_ptr) + k) % N);
            w_found    = 1'b1;
          end
        end
      end
      assign w_base_gv    = |in_valid;
      assign w_sel_bad    = 1'b0;
      assign w_unused_sel = ^sel;
    end
  endgenerate

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic r_lock;
  // While a packet is open the grant sticks to the channel of the last beat,
  // which is exactly what out_ch still holds.
  assign w_gnt       = r_lock ? out_ch : w_base_gnt;
  assign w_gv        = r_lock | w_base_gv;
  assign w_last_beat = in_last[w_gnt];

  // Packet lock: set by a non-last beat, cleared by the closing beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock   <= 1'b0;
      out_last <= 1'b0;
    end else if (w_xfer) begin
      r_lock   <= ~w_last_beat;
      out_last <= w_last_beat;
    end
  end
`else
  assign w_gnt       = w_base_gnt;
  assign w_gv        = w_base_gv;
  assign w_last_beat = 1'b1;
`endif

  assign w_xfer = w_load & w_gv & in_valid[w_gnt];

  // One-hot ready towards the granted channel only when a beat can be taken.
  always_comb begin
    in_ready = '0;
    if (w_load && w_gv) begin
      in_ready[w_gnt] = 1'b1;
    end
  end

  // Output stage: load on transfer, drop valid on a drain without refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout      <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      sel_err   <= 1'b0;
    end else begin
      if (w_xfer) begin
        dout      <= din[int'(w_gnt)*M +: M];
        out_ch    <= w_gnt;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      sel_err <= w_sel_bad;
    end
  end

  // Round-robin pointer moves past the served channel once its packet ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (MODE != 0 && w_xfer && w_last_beat) begin
      r_ptr <= (w_gnt == c_last_ch) ? '0 : w_gnt + c_one;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_mux_rr
// Purpose  : Scoreboard bench for stream_mux_rr. One round-robin instance
//            (N=4) and one external-select instance (N=3) share clock/reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_mux_rr;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic clk;
  logic rst_n;

  // Round-robin instance signals
  logic [1:0]  rr_sel;
  logic [31:0] rr_din;
  logic [3:0]  rr_valid;
  logic [3:0]  rr_ready;
  logic [7:0]  rr_dout;
  logic        rr_ov;
  logic        rr_ordy;
  logic [1:0]  rr_ch;
  logic        rr_err;
  logic [3:0]  rr_last;
  logic        rr_olast;

  // External-select instance signals
  logic [1:0]  s_sel;
  logic [23:0] s_din;
  logic [2:0]  s_valid;
  logic [2:0]  s_ready;
  logic [7:0]  s_dout;
  logic        s_ov;
  logic        s_ordy;
  logic [1:0]  s_ch;
  logic        s_err;
  logic [2:0]  s_last;
  logic        s_olast;

  beat_t q_rr[$];
  beat_t q_s[$];
  beat_t mon_rr_e;
  beat_t mon_s_e;

  int n_checks;
  int n_errors;

  stream_mux_rr #(.N(4), .M(8), .MODE(1)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (rr_sel),
    .din       (rr_din),
    .in_valid  (rr_valid),
    .in_ready  (rr_ready),
    .dout      (rr_dout),
    .out_valid (rr_ov),
    .out_ready (rr_ordy),
    .out_ch    (rr_ch),
    .sel_err   (rr_err)
`ifdef STREAM_MUX_PKT_LOCK_EN
    ,
    .in_last   (rr_last),
    .out_last  (rr_olast)
`endif
  );

  stream_mux_rr #(.N(3), .M(8), .MODE(0)) u_sel (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (s_sel),
    .din       (s_din),
    .in_valid  (s_valid),
    .in_ready  (s_ready),
    .dout      (s_dout),
    .out_valid (s_ov),
    .out_ready (s_ordy),
    .out_ch    (s_ch),
    .sel_err   (s_err)
`ifdef STREAM_MUX_PKT_LOCK_EN
    ,
    .in_last   (s_last),
    .out_last  (s_olast)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic [1:0] ch, input logic [7:0] d, input logic l);
    beat_t b;
    b.ch   = ch;
    b.data = d;
    b.last = l;
    return b;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor for the round-robin instance: a beat leaves when valid & ready.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rr_ov === 1'b1 && rr_ordy === 1'b1) begin
      if (q_rr.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rr_beat: got unexpected ch=%0d data=%h, expected no beat", rr_ch, rr_dout);
      end else begin
        mon_rr_e = q_rr.pop_front();
        check("rr_beat_ch_data", {22'd0, rr_ch, rr_dout}, {22'd0, mon_rr_e.ch, mon_rr_e.data});
`ifdef STREAM_MUX_PKT_LOCK_EN
        check("rr_beat_last", {31'd0, rr_olast}, {31'd0, mon_rr_e.last});
`endif
      end
    end
  end

  // Monitor for the external-select instance.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && s_ov === 1'b1 && s_ordy === 1'b1) begin
      if (q_s.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sel_beat: got unexpected ch=%0d data=%h, expected no beat", s_ch, s_dout);
      end else begin
        mon_s_e = q_s.pop_front();
        check("sel_beat_ch_data", {22'd0, s_ch, s_dout}, {22'd0, mon_s_e.ch, mon_s_e.data});
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    rr_sel   = 2'd0;
    rr_din   = {8'h44, 8'h33, 8'h22, 8'h11};
    rr_valid = 4'b0000;
    rr_ordy  = 1'b0;
    rr_last  = 4'b1111;
    s_sel    = 2'd0;
    s_din    = {8'h7E, 8'h5A, 8'h3C};
    s_valid  = 3'b000;
    s_ordy   = 1'b0;
    s_last   = 3'b111;

    // Reset state
    step(2);
    check("reset_rr_outputs", {20'd0, rr_dout, rr_ov, rr_ch, rr_err}, 32'd0);
    check("reset_sel_outputs", {20'd0, s_dout, s_ov, s_ch, s_err}, 32'd0);
    rst_n = 1'b1;
    step(1);

    // 1: all channels valid -> 11,22,33,44,11 on channels 0,1,2,3,0
    rr_valid = 4'b1111;
    rr_ordy  = 1'b1;
    #1;
    check("rr_first_ready", {28'd0, rr_ready}, 32'h1);
    q_rr.push_back(mk(2'd0, 8'h11, 1'b1));
    q_rr.push_back(mk(2'd1, 8'h22, 1'b1));
    q_rr.push_back(mk(2'd2, 8'h33, 1'b1));
    q_rr.push_back(mk(2'd3, 8'h44, 1'b1));
    q_rr.push_back(mk(2'd0, 8'h11, 1'b1));
    step(5);
    rr_valid = 4'b0000;
    step(2);
    check("rr_idle_drained", {31'd0, rr_ov}, 32'd0);

    // 2: channels 2 and 0 valid, pointer at 1 -> 2, 0, 2
    rr_valid = 4'b0101;
    #1;
    check("rr_skip_ready", {28'd0, rr_ready}, 32'h4);
    q_rr.push_back(mk(2'd2, 8'h33, 1'b1));
    q_rr.push_back(mk(2'd0, 8'h11, 1'b1));
    q_rr.push_back(mk(2'd2, 8'h33, 1'b1));
    step(3);
    rr_valid = 4'b0000;
    step(2);

    // 3: backpressure on beat A5 from channel 3 (pointer now at 3)
    rr_din   = {8'hA5, 8'h33, 8'h22, 8'h11};
    rr_valid = 4'b1000;
    q_rr.push_back(mk(2'd3, 8'hA5, 1'b1));
    step(1);
    rr_ordy  = 1'b0;
    rr_valid = 4'b0010;
    q_rr.push_back(mk(2'd1, 8'h22, 1'b1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_valid_data", {23'd0, rr_ov, rr_dout}, {23'd0, 1'b1, 8'hA5});
      check("bp_ready_low", {28'd0, rr_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    rr_ordy = 1'b1;
    #1;
    check("bp_release_ready", {28'd0, rr_ready}, 32'h2);
    @(posedge clk);
    #1;
    check("bp_no_gap", {29'd0, rr_ov, rr_ch}, {29'd0, 1'b1, 2'd1});
    rr_valid = 4'b0000;
    step(2);

    // 4: external select, N=3
    s_sel   = 2'd2;
    s_valid = 3'b100;
    s_ordy  = 1'b1;
    #1;
    check("sel2_ready", {29'd0, s_ready}, 32'h4);
    q_s.push_back(mk(2'd2, 8'h7E, 1'b1));
    step(1);
    s_sel   = 2'd3;
    s_valid = 3'b111;
    #1;
    check("sel3_no_ready", {29'd0, s_ready}, 32'd0);
    step(1);
    check("sel3_err_set", {31'd0, s_err}, 32'd1);
    check("sel3_drained", {31'd0, s_ov}, 32'd0);
    step(1);
    check("sel3_err_held", {31'd0, s_err}, 32'd1);
    s_sel   = 2'd1;
    s_valid = 3'b000;
    #1;
    check("sel1_ready_no_valid", {29'd0, s_ready}, 32'h2);
    step(1);
    check("sel_err_cleared", {30'd0, s_err, s_ov}, 32'd0);
    s_ordy = 1'b0;

    // 5: asynchronous reset while a beat is held (pointer at 2)
    rr_din   = {8'h44, 8'h33, 8'h22, 8'h11};
    rr_valid = 4'b0100;
    rr_ordy  = 1'b0;
    step(1);
    rr_valid = 4'b0000;
    @(negedge clk);
    check("pre_reset_held", {23'd0, rr_ov, rr_dout}, {23'd0, 1'b1, 8'h33});
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {20'd0, rr_dout, rr_ov, rr_ch, rr_err}, 32'd0);
    check("async_reset_ready", {28'd0, rr_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    rr_valid = 4'b1111;
    rr_ordy  = 1'b1;
    #1;
    check("post_reset_ready", {28'd0, rr_ready}, 32'h1);
    q_rr.push_back(mk(2'd0, 8'h11, 1'b1));
    step(1);
    rr_valid = 4'b0000;
    step(2);

`ifdef STREAM_MUX_PKT_LOCK_EN
    // 6: three-beat packet on channel 1 while channel 2 waits (pointer at 1)
    rr_last  = 4'b1100;
    rr_valid = 4'b0110;
    q_rr.push_back(mk(2'd1, 8'h22, 1'b0));
    q_rr.push_back(mk(2'd1, 8'h22, 1'b0));
    q_rr.push_back(mk(2'd1, 8'h22, 1'b1));
    q_rr.push_back(mk(2'd2, 8'h33, 1'b1));
    step(1);
    rr_valid = 4'b0100;
    #1;
    check("lock_ready_follows_held", {28'd0, rr_ready}, 32'h2);
    rr_valid = 4'b0110;
    step(1);
    rr_last = 4'b1110;
    step(1);
    step(1);
    rr_valid = 4'b0000;
    step(2);
`endif

    check("rr_queue_empty", q_rr.size(), 32'd0);
    check("sel_queue_empty", q_s.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
